uart_tx_queue: RTL and testbench



---
 rtl/uart_tx_queue.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_queue.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//
// Circular byte FIFO sitting between the receive/controller path and the
// UART transmitter. Bursts of one-cycle write strobes are absorbed into the
// FIFO while the transmitter is busy; a small FSM drains one byte per frame
// through the tx_en / tx_status handshake.
//
// Ports:
//   sys_clk      system clock (50 MHz)
//   reset        asynchronous, active-low reset
//   wr_stb       one-cycle push strobe
//   wr_data      byte pushed when wr_stb=1
//   tx_status    transmitter idle (1) / busy (0), asynchronous, synchronised here
//   tx_en        one-cycle launch pulse to the transmitter
//   tx_data      byte to transmit, held from tx_en until the frame completes
//   full         occupancy == DEPTH
//   empty        occupancy == 0
//   level        current occupancy
//   overflow     sticky, set when a push is dropped
//   timeout_err  one-cycle pulse when tx_status never falls after tx_en
//   drop_cnt     saturating count of dropped pushes (UART_TXQ_DROP_CNT_EN only)
//
// Optional feature macro: UART_TXQ_DROP_CNT_EN
// ---------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              wr_stb,
  input  logic [7:0]        wr_data,
  input  logic              tx_status,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              timeout_err
`ifdef UART_TXQ_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  // The counter lands on BUSY_TIMEOUT-1 at the same edge that raises
  // timeout_err, so the check looks one count earlier.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  busy_cnt;
  logic              ts_meta;
  logic              ts_s;
  logic              pop;
  logic              push;
  logic              drop;
  logic [ADDR_W:0]   level_next;

  // A pop only happens on the IDLE->ISSUE transition. A push is accepted
  // when there is room, or when that same edge pops and frees a slot.
  always_comb begin
    pop  = (state == IDLE) && !empty && ts_s;
    push = wr_stb && (!full || pop);
    drop = wr_stb && full && !pop;
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous transmitter status. It comes
  // out of reset reading "busy" so nothing launches until the real status
  // has been sampled.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      ts_meta <= 1'b0;
      ts_s    <= 1'b0;
    end else begin
      ts_meta <= tx_status;
      ts_s    <= ts_meta;
    end
  end

  // Storage array has no reset; validity is tracked by the pointers.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags and drop tracking, all updated on the same
  // edge as the pointer movement.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
`ifdef UART_TXQ_DROP_CNT_EN
      drop_cnt <= 8'h00;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      full  <= (level_next == DEPTH_L);
      empty <= (level_next == '0);
      if (drop) begin
        overflow <= 1'b1;
      end
`ifdef UART_TXQ_DROP_CNT_EN
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
`endif
    end
  end

  // Transmit handshake. tx_en is registered so it is high only while the
  // FSM sits in ISSUE. A timed-out byte is treated as consumed.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_en   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!ts_s) begin
            state <= WAIT_DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
            if (busy_cnt == CNT_LAST) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (ts_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Testbench for uart_tx_queue. A reference queue of bytes tracks what the
// FIFO should hold; every transmitted byte must come from its head, and the
// occupancy/flag outputs are compared against it every cycle. A simple
// transmitter model answers tx_en by going busy for a chosen number of
// cycles, or can be pinned idle (never answers) or pinned busy.
// Optional feature macro: UART_TXQ_DROP_CNT_EN
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 64;

  // Transmitter model modes
  localparam int MODE_NORMAL    = 0;
  localparam int MODE_STUCK_IDLE = 1;
  localparam int MODE_HELD_BUSY = 2;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       tx_status;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       timeout_err;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  int tx_mode   = MODE_NORMAL;
  int busy_len  = 20;
  int busy_left = 0;

  logic [7:0] model_q[$];
  logic [7:0] sent_log[$];
  logic       model_ovf = 1'b0;
  int         model_drops = 0;
  int         since_issue = 1000;
  int         edge_idx = 0;
  int         tx_count = 0;
  int         timeout_count = 0;
  int         last_tx_edge = 0;
  int         last_push_edge = 0;
  int         last_timeout_edge = 0;
  logic       prev_tx_en = 1'b0;

  // 50 MHz system clock
  always #10 sys_clk = ~sys_clk;

  uart_tx_queue #(
    .DEPTH(DEPTH),
    .ADDR_W(4),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .wr_stb(wr_stb),
    .wr_data(wr_data),
    .tx_status(tx_status),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .timeout_err(timeout_err)
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of input starting at a falling edge, returns at the next one.
  task automatic applyStimulus(input logic stb, input logic [7:0] data);
    wr_stb  = stb;
    wr_data = data;
    @(negedge sys_clk);
    wr_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00);
  endtask

  // Mode changes take effect on tx_status immediately so that synchroniser
  // timing in the directed tests does not depend on process ordering.
  task automatic setMode(input int m);
    tx_mode   = m;
    busy_left = 0;
    tx_status = (m != MODE_HELD_BUSY);
  endtask

  task automatic doReset(input int m);
    wr_stb = 1'b0;
    reset  = 1'b0;
    setMode(m);
    idle(3);
    reset = 1'b1;
    idle(2);
    sent_log.delete();
  endtask

  task automatic waitTxCount(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (tx_count < target && n < budget) begin
      idle(1);
      n++;
    end
    checkOutput(tag, 32'(tx_count >= target), 32'd1);
  endtask

  // Transmitter model: goes busy on the falling edge after it sees tx_en,
  // stays busy for busy_len cycles, then reports idle again.
  always @(negedge sys_clk) begin
    if (reset !== 1'b1) begin
      busy_left = 0;
      tx_status = (tx_mode != MODE_HELD_BUSY);
    end else if (tx_mode == MODE_HELD_BUSY) begin
      tx_status = 1'b0;
    end else if (tx_mode == MODE_STUCK_IDLE) begin
      tx_status = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_status = 1'b1;
    end else if (tx_en === 1'b1) begin
      tx_status = 1'b0;
      busy_left = busy_len;
    end else begin
      tx_status = 1'b1;
    end
  end

  // Reference model and per-cycle checks, sampled 1 ns after each rising edge.
  // A launch observed on tx_en means the head byte left at that edge; the
  // head leaves before any push of the same edge is considered.
  always @(posedge sys_clk) begin
    logic       stb;
    logic [7:0] dat;
    logic       popped;
    stb = wr_stb;
    dat = wr_data;
    edge_idx++;
    #1;
    if (reset !== 1'b1) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_drops = 0;
      since_issue = 1000;
      prev_tx_en  = 1'b0;
    end else begin
      popped = (tx_en === 1'b1);
      if (popped) begin
        tx_count++;
        last_tx_edge = edge_idx;
        since_issue  = 0;
        checkOutput("tx_en_single_cycle", 32'(prev_tx_en), 32'd0);
        checkOutput("pop_when_nonempty", 32'(model_q.size() != 0), 32'd1);
        if (model_q.size() != 0) begin
          checkOutput("tx_data_order", 32'(tx_data), 32'(model_q[0]));
          sent_log.push_back(model_q.pop_front());
        end
      end else if (since_issue < 1000) begin
        since_issue++;
      end
      if (stb) begin
        last_push_edge = edge_idx;
        if (model_q.size() < DEPTH) begin
          model_q.push_back(dat);
        end else begin
          model_ovf = 1'b1;
          if (model_drops < 255) model_drops++;
        end
      end
      if (timeout_err === 1'b1) begin
        timeout_count++;
        last_timeout_edge = edge_idx;
      end
      checkOutput("level", 32'(level), 32'(model_q.size()));
      checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
      checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
      checkOutput("overflow", 32'(overflow), 32'(model_ovf));
      checkOutput("timeout_err", 32'(timeout_err),
                  32'(tx_mode == MODE_STUCK_IDLE && since_issue == BUSY_TIMEOUT));
`ifdef UART_TXQ_DROP_CNT_EN
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(model_drops));
`endif
      prev_tx_en = popped;
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int         base;
    int         tc_base;
    int         first_issue;
    int         n;
    logic [7:0] ovf_bytes[18];

    reset     = 1'b0;
    wr_stb    = 1'b0;
    wr_data   = 8'h00;
    tx_status = 1'b1;
    tx_mode   = MODE_NORMAL;
    @(negedge sys_clk);

    $display("[TB] reset values");
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(100);
    checkOutput("idle_tx_count", 32'(tx_count), 32'd0);
    checkOutput("idle_empty", 32'(empty), 32'd1);
    checkOutput("idle_level", 32'(level), 32'd0);

    $display("[TB] single byte");
    busy_len = 20;
    base = tx_count;
    applyStimulus(1'b1, 8'hA5);
    waitTxCount("single_issue", base + 1, 10);
    // wr_stb occupied the cycle ending at last_push_edge; tx_en occupies the
    // cycle starting at last_tx_edge. The cycle distance between them is 2.
    checkOutput("single_latency", 32'(last_tx_edge - last_push_edge + 1), 32'd2);
    checkOutput("single_data", 32'(tx_data), 32'hA5);
    idle(40);
    checkOutput("single_count", 32'(tx_count - base), 32'd1);
    checkOutput("single_empty_after", 32'(empty), 32'd1);

    $display("[TB] burst and order");
    setMode(MODE_HELD_BUSY);
    idle(4);
    base = tx_count;
    sent_log.delete();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i));
    checkOutput("burst_level", 32'(level), 32'd16);
    checkOutput("burst_full", 32'(full), 32'd1);
    busy_len = 6;
    setMode(MODE_NORMAL);
    waitTxCount("burst_drain", base + 16, 1000);
    idle(20);
    checkOutput("burst_sent_count", 32'(sent_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent_log.size()) checkOutput("burst_order", 32'(sent_log[i]), 32'(i + 1));
    end
    checkOutput("burst_no_overflow", 32'(overflow), 32'd0);

    $display("[TB] overflow");
    doReset(MODE_HELD_BUSY);
    base = tx_count;
    for (int i = 0; i < 18; i++) begin
      ovf_bytes[i] = 8'($urandom);
      applyStimulus(1'b1, ovf_bytes[i]);
    end
    checkOutput("ovf_level", 32'(level), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
`ifdef UART_TXQ_DROP_CNT_EN
    checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    setMode(MODE_NORMAL);
    waitTxCount("ovf_drain", base + 16, 1000);
    idle(100);
    checkOutput("ovf_sent_count", 32'(tx_count - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent_log.size()) checkOutput("ovf_order", 32'(sent_log[i]), 32'(ovf_bytes[i]));
    end
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] full with simultaneous pop");
    doReset(MODE_HELD_BUSY);
    base = tx_count;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h80 + i));
    checkOutput("fullpop_pre_full", 32'(full), 32'd1);
    // tx_status rises here; two synchroniser edges later the FSM pops.
    setMode(MODE_NORMAL);
    idle(2);
    applyStimulus(1'b1, 8'h55);
    checkOutput("fullpop_same_edge", 32'(last_tx_edge), 32'(last_push_edge));
    checkOutput("fullpop_level", 32'(level), 32'd16);
    checkOutput("fullpop_no_overflow", 32'(overflow), 32'd0);
    waitTxCount("fullpop_drain", base + 17, 2000);
    idle(20);
    checkOutput("fullpop_sent_count", 32'(sent_log.size()), 32'd17);
    if (sent_log.size() != 0) checkOutput("fullpop_last_byte", 32'(sent_log[sent_log.size() - 1]), 32'h55);

    $display("[TB] handshake timeout");
    doReset(MODE_STUCK_IDLE);
    base    = tx_count;
    tc_base = timeout_count;
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'hC3);
    waitTxCount("to_first_issue", base + 1, 10);
    first_issue = last_tx_edge;
    n = 0;
    while (timeout_count == tc_base && n < 100) begin
      idle(1);
      n++;
    end
    checkOutput("to_pulse_seen", 32'(timeout_count - tc_base), 32'd1);
    checkOutput("to_delay", 32'(last_timeout_edge - first_issue), 32'(BUSY_TIMEOUT));
    waitTxCount("to_second_issue", base + 2, 10);
    checkOutput("to_reissue_gap", 32'(last_tx_edge - last_timeout_edge), 32'd1);
    idle(80);
    checkOutput("to_total_pulses", 32'(timeout_count - tc_base), 32'd2);
    checkOutput("to_empty", 32'(empty), 32'd1);

    $display("[TB] reset during frame");
    busy_len = 20;
    setMode(MODE_NORMAL);
    idle(4);
    base = tx_count;
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    waitTxCount("rst_mid_issue", base + 1, 10);
    idle(8);
    checkOutput("rst_mid_pre_level", 32'(level), 32'd2);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_mid_level", 32'(level), 32'd0);
    checkOutput("rst_mid_empty", 32'(empty), 32'd1);
    @(negedge sys_clk);
    idle(1);
    reset = 1'b1;
    idle(3);
    sent_log.delete();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        n = ($urandom_range(0, 3) == 0) ? MODE_HELD_BUSY : MODE_NORMAL;
        if (n != tx_mode) setMode(n);
      end
      busy_len = $urandom_range(1, 8);
      applyStimulus($urandom_range(0, 99) < 45, 8'($urandom));
    end
    if (tx_mode != MODE_NORMAL) setMode(MODE_NORMAL);
    n = 0;
    while (model_q.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    checkOutput("random_drained", 32'(model_q.size()), 32'd0);
    idle(40);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
